// File: rtl/pic_seq_pkg.sv
// Shared types, constants and init-list helpers for the 8259A host sequencer.
package pic_seq_pkg;

    typedef enum logic [2:0] {
        IDLE, W_SETUP, W_STROBE, W_HOLD, W_GAP, INTA_LO, INTA_HI, VEC_WAIT
    } state_e;

    typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD, PH_GAP} phase_e;

    typedef enum logic [2:0] {WD_ICW1, WD_ICW2, WD_ICW3, WD_ICW4, WD_OCW1} word_e;

    typedef struct packed {
        logic [7:0] icw1;
        logic [7:0] icw2;
        logic [7:0] icw3;
        logic [7:0] icw4;
        logic [7:0] ocw1;
    } init_words_t;

    localparam logic       A0_CMD    = 1'b0;
    localparam logic       A0_DATA   = 1'b1;
    localparam int         ICW1_SNGL = 1;
    localparam int         ICW1_IC4  = 0;
    localparam int         ICW4_UPM  = 0;
    localparam logic [2:0] OCW2_SEOI = 3'b011;

    // ICW3 exists only in cascade mode, ICW4 only when ICW1 asks for it.
    function automatic word_e next_word(word_e cur, logic [7:0] icw1);
        word_e nxt;
        nxt = WD_OCW1;
        case (cur)
            WD_ICW1: nxt = WD_ICW2;
            WD_ICW2: nxt = !icw1[ICW1_SNGL] ? WD_ICW3 : (icw1[ICW1_IC4] ? WD_ICW4 : WD_OCW1);
            WD_ICW3: nxt = icw1[ICW1_IC4] ? WD_ICW4 : WD_OCW1;
            default: nxt = WD_OCW1;
        endcase
        return nxt;
    endfunction

    function automatic logic [7:0] word_data(init_words_t w, word_e sel);
        logic [7:0] d;
        d = w.ocw1;
        case (sel)
            WD_ICW1: d = w.icw1;
            WD_ICW2: d = w.icw2;
            WD_ICW3: d = w.icw3;
            WD_ICW4: d = w.icw4;
            default: d = w.ocw1;
        endcase
        return d;
    endfunction

    function automatic logic upm_mode(init_words_t w);
        return w.icw1[ICW1_IC4] ? w.icw4[ICW4_UPM] : 1'b0;
    endfunction

endpackage

// File: rtl/pic_host_sequencer_if.sv
// Fabric-side and PIC-side signal bundle; master is the sequencer, slave its environment.
interface pic_host_sequencer_if;
    logic        cfg_start;
    logic [7:0]  cfg_icw1, cfg_icw2, cfg_icw3, cfg_icw4, cfg_ocw1;
    logic        cfg_busy, cfg_done;
    logic        pic_chip_select_n, pic_write_enable_n, pic_read_enable_n;
    logic        pic_address;
    logic [7:0]  pic_data_out;
    logic        pic_data_oe;
    logic [7:0]  pic_data_in;
    logic        pic_interrupt;
    logic        pic_interrupt_acknowledge_n;
    logic        vec_valid;
    logic [15:0] vec_data;
    logic        vec_ready;
    logic        eoi_valid;
    logic [2:0]  eoi_level;
    logic        eoi_ready;

    modport master (
        input  cfg_start, cfg_icw1, cfg_icw2, cfg_icw3, cfg_icw4, cfg_ocw1,
               pic_data_in, pic_interrupt, vec_ready, eoi_valid, eoi_level,
        output cfg_busy, cfg_done, pic_chip_select_n, pic_write_enable_n,
               pic_read_enable_n, pic_address, pic_data_out, pic_data_oe,
               pic_interrupt_acknowledge_n, vec_valid, vec_data, eoi_ready
    );

    modport slave (
        output cfg_start, cfg_icw1, cfg_icw2, cfg_icw3, cfg_icw4, cfg_ocw1,
               pic_data_in, pic_interrupt, vec_ready, eoi_valid, eoi_level,
        input  cfg_busy, cfg_done, pic_chip_select_n, pic_write_enable_n,
               pic_read_enable_n, pic_address, pic_data_out, pic_data_oe,
               pic_interrupt_acknowledge_n, vec_valid, vec_data, eoi_ready
    );
endinterface

// File: rtl/pic_bus_write_timer.sv
// Shared phase down-counter: start_i loads the selected phase length, done_o marks its last cycle.
module pic_bus_write_timer
    import pic_seq_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1,
    parameter int GAP_CYCLES   = 1
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   start_i,
    input  phase_e phase_i,
    output logic   done_o
);
    localparam int MAX_SP  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_CYC = (MAX_SP > MAX_HG) ? MAX_SP : MAX_HG;
    localparam int CW      = $clog2(MAX_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d, load_val;

    always_comb begin
        // NOTE: every combinational output gets a default before the case so no latch is inferred.
        load_val = '0;
        unique case (phase_i)
            PH_SETUP: load_val = CW'(SETUP_CYCLES - 1);
            PH_PULSE: load_val = CW'(PULSE_CYCLES - 1);
            PH_HOLD:  load_val = CW'(HOLD_CYCLES - 1);
            PH_GAP:   load_val = CW'(GAP_CYCLES - 1);
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (start_i)             cnt_d = load_val;
        else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);
endmodule

// File: rtl/pic_host_sequencer.sv
// 8259A host sequencer: init word list, INTA trains with vector capture, optional
// specific-EOI writes when PIC_SEQ_EOI_EN is defined.
module pic_host_sequencer
    import pic_seq_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                clock,
    input  logic                reset,
    pic_host_sequencer_if.master bus
);
    if (SETUP_CYCLES < 1 || PULSE_CYCLES < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_params
        $error("pic_host_sequencer: all timing parameters must be >= 1");
    end

    state_e      state_q, state_d;
    init_words_t words_q, words_d;
    word_e       idx_q, idx_d;
    logic        eoi_op_q, eoi_op_d;
    logic        addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        init_ok_q, init_ok_d;
    logic [1:0]  pulse_q, pulse_d;
    logic [15:0] vec_q, vec_d;
    logic        tmr_start, tmr_done, eoi_ready_c, upm;
    phase_e      tmr_phase;

    pic_bus_write_timer #(
        .SETUP_CYCLES(SETUP_CYCLES), .PULSE_CYCLES(PULSE_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),   .GAP_CYCLES(GAP_CYCLES)
    ) u_timer (
        .clock(clock), .reset(reset), .start_i(tmr_start), .phase_i(tmr_phase), .done_o(tmr_done)
    );

    assign upm = upm_mode(words_q);

    always_comb begin
        state_d = state_q;  words_d = words_q;  idx_d = idx_q;  eoi_op_d = eoi_op_q;
        addr_d = addr_q;    wdata_d = wdata_q;  busy_d = busy_q; done_d = 1'b0;
        init_ok_d = init_ok_q; pulse_d = pulse_q; vec_d = vec_q;
        tmr_start = 1'b0;   tmr_phase = PH_SETUP; eoi_ready_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cfg_start) begin
                    words_d   = '{bus.cfg_icw1, bus.cfg_icw2, bus.cfg_icw3, bus.cfg_icw4, bus.cfg_ocw1};
                    idx_d     = WD_ICW1;   eoi_op_d = 1'b0;
                    addr_d    = A0_CMD;    wdata_d  = bus.cfg_icw1;
                    busy_d    = 1'b1;      init_ok_d = 1'b0;
                    state_d   = W_SETUP;   tmr_start = 1'b1;
`ifdef PIC_SEQ_EOI_EN
                end else if (bus.eoi_valid && init_ok_q) begin
                    eoi_ready_c = 1'b1;    eoi_op_d = 1'b1;
                    addr_d    = A0_CMD;    wdata_d  = {OCW2_SEOI, 2'b00, bus.eoi_level};
                    state_d   = W_SETUP;   tmr_start = 1'b1;
`endif
                end else if (bus.pic_interrupt && init_ok_q) begin
                    pulse_d   = 2'd0;      state_d = INTA_LO;
                    tmr_start = 1'b1;      tmr_phase = PH_PULSE;
                end
            end
            W_SETUP:  if (tmr_done) begin state_d = W_STROBE; tmr_start = 1'b1; tmr_phase = PH_PULSE; end
            W_STROBE: if (tmr_done) begin state_d = W_HOLD;   tmr_start = 1'b1; tmr_phase = PH_HOLD;  end
            W_HOLD:   if (tmr_done) begin state_d = W_GAP;    tmr_start = 1'b1; tmr_phase = PH_GAP;   end
            W_GAP: if (tmr_done) begin
                if (eoi_op_q) begin
                    state_d = IDLE;
                end else if (idx_q == WD_OCW1) begin
                    state_d = IDLE; busy_d = 1'b0; done_d = 1'b1; init_ok_d = 1'b1;
                end else begin
                    idx_d   = next_word(idx_q, words_q.icw1);
                    addr_d  = A0_DATA;
                    wdata_d = word_data(words_q, idx_d);
                    state_d = W_SETUP; tmr_start = 1'b1;
                end
            end
            INTA_LO: if (tmr_done) begin
                // The bus is sampled on the last low cycle, when the PIC's data is settled.
                if (pulse_q == 2'd1) begin
                    if (upm) vec_d = {8'h00, bus.pic_data_in};
                    else     vec_d[7:0] = bus.pic_data_in;
                end else if (pulse_q == 2'd2) begin
                    vec_d[15:8] = bus.pic_data_in;
                end
                state_d = INTA_HI; tmr_start = 1'b1; tmr_phase = PH_GAP;
            end
            INTA_HI: if (tmr_done) begin
                if (pulse_q == (upm ? 2'd1 : 2'd2)) begin
                    state_d = VEC_WAIT;
                end else begin
                    pulse_d = pulse_q + 2'd1;
                    state_d = INTA_LO; tmr_start = 1'b1; tmr_phase = PH_PULSE;
                end
            end
            VEC_WAIT: if (bus.vec_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;   words_q <= '0;     idx_q <= WD_ICW1;  eoi_op_q <= 1'b0;
            addr_q <= A0_CMD;  wdata_q <= '0;     busy_q <= 1'b0;    done_q <= 1'b0;
            init_ok_q <= 1'b0; pulse_q <= '0;     vec_q <= '0;
        end else begin
            state_q <= state_d; words_q <= words_d; idx_q <= idx_d;   eoi_op_q <= eoi_op_d;
            addr_q <= addr_d;   wdata_q <= wdata_d; busy_q <= busy_d; done_q <= done_d;
            init_ok_q <= init_ok_d; pulse_q <= pulse_d; vec_q <= vec_d;
        end
    end

`ifndef PIC_SEQ_EOI_EN
    logic unused_eoi;
    assign unused_eoi = ^{bus.eoi_valid, bus.eoi_level};
`endif

    logic cs_active;
    assign cs_active                       = (state_q == W_SETUP) || (state_q == W_STROBE) || (state_q == W_HOLD);
    assign bus.pic_chip_select_n           = !cs_active;
    assign bus.pic_data_oe                 = cs_active;
    assign bus.pic_write_enable_n          = (state_q != W_STROBE);
    assign bus.pic_read_enable_n           = 1'b1;
    assign bus.pic_address                 = addr_q;
    assign bus.pic_data_out                = wdata_q;
    assign bus.pic_interrupt_acknowledge_n = (state_q != INTA_LO);
    assign bus.cfg_busy                    = busy_q;
    assign bus.cfg_done                    = done_q;
    assign bus.vec_valid                   = (state_q == VEC_WAIT);
    assign bus.vec_data                    = vec_q;
    assign bus.eoi_ready                   = eoi_ready_c;
endmodule

// File: tb/tb_pic_host_sequencer.sv
// Directed bench for pic_host_sequencer: init-list table, INTA vector capture and reset/EOI corners.
module tb_pic_host_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pic_host_sequencer_if bus();

    pic_host_sequencer #(
        .SETUP_CYCLES(1), .PULSE_CYCLES(2), .HOLD_CYCLES(1), .GAP_CYCLES(1)
    ) dut (
        .clock(clk), .reset(rst), .bus(bus.master)
    );

    typedef struct packed {
        logic [7:0]        icw1, icw2, icw3, icw4, ocw1;
        int                n_wr;
        logic [0:4][8:0]   wr;
        logic [0:2][7:0]   bytes;
        int                n_pulse;
        logic [15:0]       vec;
    } vec_t;

    vec_t tbl[5];
    int   n_cmp = 0;
    int   n_fail = 0;

    // Bus monitor and PIC data model: sole writer of these counters and of pic_data_in.
    int         cyc = 0, n_wr = 0, wr_low = 0, bad_wr = 0;
    int         n_inta = 0, inta_low = 0, bad_inta = 0, inta_idx = 0;
    int         n_done = 0, n_eoi = 0;
    logic [8:0] wr_log[128];
    logic       wr_prev = 1'b1, inta_prev = 1'b1;
    logic [7:0] pic_bytes[3];

    always @(negedge clk) begin
        cyc++;
        if (!bus.pic_write_enable_n) begin
            if (wr_prev) begin
                if (n_wr < 128) wr_log[n_wr] = {bus.pic_address, bus.pic_data_out};
                n_wr++;
                wr_low = 0;
            end
            wr_low++;
            if (bus.pic_chip_select_n || !bus.pic_data_oe) bad_wr++;
        end else if (!wr_prev && wr_low != 2) begin
            bad_wr++;
        end
        wr_prev = bus.pic_write_enable_n;

        if (rst || bus.vec_valid) inta_idx = 0;
        if (!bus.pic_interrupt_acknowledge_n) begin
            if (inta_prev) begin
                n_inta++;
                inta_idx++;
                inta_low = 0;
            end
            inta_low++;
        end else if (!inta_prev && inta_low != 2) begin
            bad_inta++;
        end
        inta_prev = bus.pic_interrupt_acknowledge_n;
        bus.pic_data_in = (!bus.pic_interrupt_acknowledge_n && inta_idx >= 1 && inta_idx <= 3)
                          ? pic_bytes[inta_idx-1] : 8'hFF;

        if (bus.cfg_done)  n_done++;
        if (bus.eoi_ready) n_eoi++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_init(input logic [7:0] i1, i2, i3, i4, o1);
        bus.cfg_icw1 = i1; bus.cfg_icw2 = i2; bus.cfg_icw3 = i3;
        bus.cfg_icw4 = i4; bus.cfg_ocw1 = o1;
        bus.cfg_start = 1'b1;
        step();
        bus.cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cnt = 0;
        while (!bus.cfg_done && cnt < 300) begin step(); cnt++; end
        check({name, "_done_seen"}, bus.cfg_done, 1'b1);
    endtask

    task automatic wait_vec(input string name);
        int cnt = 0;
        while (!bus.vec_valid && cnt < 300) begin step(); cnt++; end
        check({name, "_vec_valid"}, bus.vec_valid, 1'b1);
    endtask

    task automatic wait_inta_from(input int base);
        int cnt = 0;
        while (n_inta == base && cnt < 300) begin step(); cnt++; end
        check("inta_started", (n_inta > base), 1'b1);
    endtask

    task automatic accept_vec(input string name);
        bus.vec_ready = 1'b1;
        step();
        bus.vec_ready = 1'b0;
        check({name, "_vec_released"}, bus.vec_valid, 1'b0);
    endtask

    initial begin
        int wr_b, bad_b, done_b, inta_b, binta_b, eoi_b, cnt;

        tbl[0] = '{8'h13, 8'h20, 8'hAA, 8'h01, 8'hFB, 4, {9'h013, 9'h120, 9'h101, 9'h1FB, 9'h000},
                   {8'hFF, 8'h21, 8'hFF}, 2, 16'h0021};
        tbl[1] = '{8'h11, 8'h08, 8'h04, 8'h01, 8'h00, 5, {9'h011, 9'h108, 9'h104, 9'h101, 9'h100},
                   {8'h00, 8'h0D, 8'h77}, 2, 16'h000D};
        tbl[2] = '{8'h12, 8'h40, 8'h55, 8'h66, 8'hF0, 3, {9'h012, 9'h140, 9'h1F0, 9'h000, 9'h000},
                   {8'hCD, 8'h44, 8'h12}, 3, 16'h1244};
        tbl[3] = '{8'h10, 8'h30, 8'h02, 8'h99, 8'h7F, 4, {9'h010, 9'h130, 9'h102, 9'h17F, 9'h000},
                   {8'hCD, 8'h9A, 8'hBC}, 3, 16'hBC9A};
        tbl[4] = '{8'h13, 8'h50, 8'hEE, 8'h00, 8'hFF, 4, {9'h013, 9'h150, 9'h100, 9'h1FF, 9'h000},
                   {8'h11, 8'h22, 8'h33}, 3, 16'h3322};

        bus.cfg_start = 1'b0; bus.cfg_icw1 = '0; bus.cfg_icw2 = '0; bus.cfg_icw3 = '0;
        bus.cfg_icw4 = '0; bus.cfg_ocw1 = '0; bus.pic_interrupt = 1'b0; bus.vec_ready = 1'b0;
        bus.eoi_valid = 1'b0; bus.eoi_level = '0;
        for (int i = 0; i < 3; i++) pic_bytes[i] = 8'hFF;

        repeat (3) step();
        check("rst_cs_n",   bus.pic_chip_select_n, 1'b1);
        check("rst_wr_n",   bus.pic_write_enable_n, 1'b1);
        check("rst_rd_n",   bus.pic_read_enable_n, 1'b1);
        check("rst_inta_n", bus.pic_interrupt_acknowledge_n, 1'b1);
        check("rst_oe",     bus.pic_data_oe, 1'b0);
        check("rst_addr",   bus.pic_address, 1'b0);
        check("rst_data",   bus.pic_data_out, 8'h00);
        check("rst_busy",   bus.cfg_busy, 1'b0);
        check("rst_done",   bus.cfg_done, 1'b0);
        check("rst_vvalid", bus.vec_valid, 1'b0);
        check("rst_vdata",  bus.vec_data, 16'h0000);
        check("rst_eoirdy", bus.eoi_ready, 1'b0);
        rst = 1'b0;

        // INT must be ignored until an init list has completed.
        inta_b = n_inta;
        bus.pic_interrupt = 1'b1;
        repeat (20) step();
        bus.pic_interrupt = 1'b0;
        check("no_inta_before_init", n_inta - inta_b, 0);

        for (int r = 0; r < 5; r++) begin
            wr_b = n_wr; bad_b = bad_wr; done_b = n_done;
            start_init(tbl[r].icw1, tbl[r].icw2, tbl[r].icw3, tbl[r].icw4, tbl[r].ocw1);
            check($sformatf("row%0d_busy_rise", r), bus.cfg_busy, 1'b1);
            wait_done($sformatf("row%0d", r));
            check($sformatf("row%0d_busy_fall", r), bus.cfg_busy, 1'b0);
            repeat (3) step();
            check($sformatf("row%0d_done_count", r), n_done - done_b, 1);
            check($sformatf("row%0d_write_count", r), n_wr - wr_b, tbl[r].n_wr);
            for (int k = 0; k < tbl[r].n_wr; k++)
                check($sformatf("row%0d_write%0d", r, k), wr_log[wr_b + k], tbl[r].wr[k]);
            check($sformatf("row%0d_wr_timing", r), bad_wr - bad_b, 0);

            for (int i = 0; i < 3; i++) pic_bytes[i] = tbl[r].bytes[i];
            inta_b = n_inta; binta_b = bad_inta;
            bus.pic_interrupt = 1'b1;
            wait_inta_from(inta_b);
            bus.pic_interrupt = 1'b0;
            wait_vec($sformatf("row%0d", r));
            check($sformatf("row%0d_pulses", r), n_inta - inta_b, tbl[r].n_pulse);
            check($sformatf("row%0d_vec", r), bus.vec_data, tbl[r].vec);
            for (int h = 0; h < 3; h++) begin
                step();
                check($sformatf("row%0d_hold_valid%0d", r, h), bus.vec_valid, 1'b1);
                check($sformatf("row%0d_hold_data%0d", r, h), bus.vec_data, tbl[r].vec);
            end
            accept_vec($sformatf("row%0d", r));
            check($sformatf("row%0d_inta_width", r), bad_inta - binta_b, 0);
        end

        // Accept with INT still high: the next train must not start in the release cycle.
        inta_b = n_inta;
        bus.pic_interrupt = 1'b1;
        wait_vec("b2b_first");
        accept_vec("b2b_first");
        check("b2b_gap_inta_n", bus.pic_interrupt_acknowledge_n, 1'b1);
        wait_inta_from(inta_b + 3);
        bus.pic_interrupt = 1'b0;
        wait_vec("b2b_second");
        check("b2b_pulses", n_inta - inta_b, 6);
        check("b2b_vec", bus.vec_data, 16'h3322);
        accept_vec("b2b_second");

        // A second cfg_start while busy must neither relatch nor restart.
        wr_b = n_wr; done_b = n_done;
        start_init(8'h13, 8'h20, 8'hAA, 8'h01, 8'hFB);
        repeat (3) step();
        start_init(8'h11, 8'h08, 8'h04, 8'h01, 8'h00);
        wait_done("ignore_start");
        repeat (30) step();
        check("ignore_start_writes", n_wr - wr_b, 4);
        check("ignore_start_w0", wr_log[wr_b], 9'h013);
        check("ignore_start_w3", wr_log[wr_b + 3], 9'h1FB);
        check("ignore_start_done", n_done - done_b, 1);

`ifdef PIC_SEQ_EOI_EN
        pic_bytes[0] = 8'hFF; pic_bytes[1] = 8'h42; pic_bytes[2] = 8'hFF;
        wr_b = n_wr; inta_b = n_inta; eoi_b = n_eoi;
        bus.eoi_valid = 1'b1; bus.eoi_level = 3'd5; bus.pic_interrupt = 1'b1;
        cnt = 0;
        while (!bus.eoi_ready && cnt < 50) begin step(); cnt++; end
        check("eoi_ready_seen", bus.eoi_ready, 1'b1);
        step();
        bus.eoi_valid = 1'b0;
        wait_inta_from(inta_b);
        check("eoi_write_before_inta", n_wr - wr_b, 1);
        check("eoi_ocw2", wr_log[wr_b], 9'h065);
        bus.pic_interrupt = 1'b0;
        wait_vec("eoi");
        check("eoi_vec", bus.vec_data, 16'h0042);
        accept_vec("eoi");
        check("eoi_ready_pulses", n_eoi - eoi_b, 1);
`else
        wr_b = n_wr; eoi_b = n_eoi;
        bus.eoi_valid = 1'b1; bus.eoi_level = 3'd5;
        repeat (10) step();
        bus.eoi_valid = 1'b0;
        check("eoi_disabled_ready", n_eoi - eoi_b, 0);
        check("eoi_disabled_writes", n_wr - wr_b, 0);
`endif

        // Reset in the middle of an INTA pulse must also drop init_ok.
        inta_b = n_inta;
        bus.pic_interrupt = 1'b1;
        cnt = 0;
        while (bus.pic_interrupt_acknowledge_n && cnt < 50) begin step(); cnt++; end
        check("rst_inta_reached", bus.pic_interrupt_acknowledge_n, 1'b0);
        rst = 1'b1;
        step();
        check("rst_inta_inta_n", bus.pic_interrupt_acknowledge_n, 1'b1);
        check("rst_inta_cs_n",   bus.pic_chip_select_n, 1'b1);
        check("rst_inta_vvalid", bus.vec_valid, 1'b0);
        rst = 1'b0;
        inta_b = n_inta;
        repeat (20) step();
        check("rst_inta_init_ok", n_inta - inta_b, 0);
        bus.pic_interrupt = 1'b0;

        // Reset while WR_n is low.
        done_b = n_done;
        start_init(8'h13, 8'h20, 8'hAA, 8'h01, 8'hFB);
        cnt = 0;
        while (bus.pic_write_enable_n && cnt < 50) begin step(); cnt++; end
        check("rst_wr_reached", bus.pic_write_enable_n, 1'b0);
        rst = 1'b1;
        step();
        check("rst_wr_wr_n", bus.pic_write_enable_n, 1'b1);
        check("rst_wr_cs_n", bus.pic_chip_select_n, 1'b1);
        check("rst_wr_oe",   bus.pic_data_oe, 1'b0);
        check("rst_wr_busy", bus.cfg_busy, 1'b0);
        check("rst_wr_data", bus.pic_data_out, 8'h00);
        rst = 1'b0;
        inta_b = n_inta;
        bus.pic_interrupt = 1'b1;
        repeat (30) step();
        bus.pic_interrupt = 1'b0;
        check("rst_wr_no_done", n_done - done_b, 0);
        check("rst_wr_init_ok", n_inta - inta_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
